cache_ctrl: RTL and testbench

Sequencing controller for the single-cycle RISC-V core's direct-mapped data cache. It holds the tag and valid arrays and turns the decoder's `MemReadCpu`/`MemWrite` strobes into hit/miss decisions. It also drives the CPU `stall` and sequences block refills and write-through writes to main memory over a request/ready handshake. It sits between the core's data-access port, the cache data array (word-addressed RAM outside this block) and main memory.

---
 rtl/cache_ctrl.sv | 129 ++++++++++++
 tb/tb_cache_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Direct-mapped data-cache controller: tag/valid arrays, hit/miss decision,
// block refill and write-through store sequencing over a request/ready handshake.
module cache_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        MemReadCpu,
  input  logic                        MemWrite,
  input  logic [ADDR_W-1:0]           cpu_addr,
  output logic                        hit,
  output logic                        stall,
  output logic                        cache_we,
  output logic [INDEX_W+OFFSET_W-1:0] cache_waddr,
  output logic                        cache_wsel,
  output logic                        mem_rd,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ready
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE_MEM, RESUME} state_t;

  state_t                       state, state_nx;
  logic [OFFSET_W-1:0]          word_cnt;
  logic [ADDR_W-1:0]            lat_addr;
  logic                         lat_hit;
  logic [LINES-1:0]             valid;
  logic [LINES-1:0][TAG_W-1:0]  tags;

  logic [TAG_W-1:0]    cpu_tag, lat_tag;
  logic [INDEX_W-1:0]  cpu_idx, lat_idx;
  logic [OFFSET_W-1:0] lat_off;
  logic                last_word;

  assign cpu_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_idx   = cpu_addr[OFFSET_W +: INDEX_W];
  assign lat_tag   = lat_addr[ADDR_W-1 -: TAG_W];
  assign lat_idx   = lat_addr[OFFSET_W +: INDEX_W];
  assign lat_off   = lat_addr[OFFSET_W-1:0];
  assign last_word = &word_cnt;

  assign hit = valid[cpu_idx] && (tags[cpu_idx] == cpu_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      valid    <= '0;
      lat_addr <= '0;
      lat_hit  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          // store wins over a simultaneous load
          if (MemWrite) begin
            lat_addr <= cpu_addr;
            lat_hit  <= hit;
          end else if (MemReadCpu && !hit) begin
            lat_addr <= cpu_addr;
            word_cnt <= '0;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            word_cnt <= word_cnt + 1'b1;
            if (last_word) valid[lat_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tags need no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ready && last_word) tags[lat_idx] <= lat_tag;
  end

  always_comb begin
    state_nx    = state;
    stall       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    cache_we    = 1'b0;
    cache_waddr = '0;
    cache_wsel  = 1'b0;
    case (state)
      IDLE: begin
        if (MemWrite) begin
          stall    = 1'b1;
          state_nx = WRITE_MEM;
        end else if (MemReadCpu && !hit) begin
          stall    = 1'b1;
          state_nx = REFILL;
        end
      end
      REFILL: begin
        stall       = 1'b1;
        mem_rd      = 1'b1;
        mem_addr    = {lat_tag, lat_idx, word_cnt};
        cache_wsel  = 1'b1;
        cache_waddr = {lat_idx, word_cnt};
        if (mem_ready) begin
          cache_we = 1'b1;
          if (last_word) state_nx = RESUME;
        end
      end
      WRITE_MEM: begin
        stall       = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = lat_addr;
        cache_waddr = {lat_idx, lat_off};
        if (mem_ready) begin
          cache_we = lat_hit;
          state_nx = RESUME;
        end
      end
      RESUME:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: memory responder with programmable wait states,
// scoreboard queues for memory requests and data-array writes.
module tb_cache_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       MemReadCpu = 1'b0, MemWrite = 1'b0;
  logic [9:0] cpu_addr = '0;
  logic       hit, stall, cache_we, cache_wsel, mem_rd, mem_wr;
  logic [6:0] cache_waddr;
  logic [9:0] mem_addr;
  logic       mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int wait_cfg = 0;
  int waitc = 0;

  logic [10:0] exp_mem[$];  // {is_write, addr}
  logic [7:0]  exp_cw[$];   // {wsel, waddr}

  cache_ctrl dut (
    .clk(clk), .rst(rst), .MemReadCpu(MemReadCpu), .MemWrite(MemWrite),
    .cpu_addr(cpu_addr), .hit(hit), .stall(stall), .cache_we(cache_we),
    .cache_waddr(cache_waddr), .cache_wsel(cache_wsel), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: memory responder drives ready just after the edge, then the
  // scoreboard checks request and data-array write activity of this cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_rd || mem_wr) begin
      if (waitc >= wait_cfg) begin mem_ready = 1'b1; waitc = 0; end
      else begin mem_ready = 1'b0; waitc++; end
    end else begin
      mem_ready = 1'b0;
      waitc = 0;
    end
    #1;
    if (mem_rd || mem_wr) begin
      if (exp_mem.size() == 0) chk("unexpected_mem_req", {mem_rd, mem_wr, 20'd0, mem_addr}, 32'd0);
      else begin
        chk("mem_req", {21'd0, mem_wr, mem_addr}, {21'd0, exp_mem[0]});
        chk("mem_rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
        if (mem_ready) void'(exp_mem.pop_front());
      end
    end
    if (cache_we) begin
      if (exp_cw.size() == 0) chk("unexpected_cache_we", {24'd0, cache_wsel, cache_waddr}, 32'd0);
      else chk("cache_write", {24'd0, cache_wsel, cache_waddr}, {24'd0, exp_cw.pop_front()});
    end
  endtask

  task automatic exp_refill(input logic [9:0] a, input int n);
    logic [1:0] wb;
    for (int w = 0; w < n; w++) begin
      wb = w[1:0];
      exp_mem.push_back({1'b0, a[9:2], wb});
      exp_cw.push_back({1'b1, a[6:2], wb});
    end
  endtask

  task automatic exp_store(input logic [9:0] a, input logic h);
    exp_mem.push_back({1'b1, a});
    if (h) exp_cw.push_back({1'b0, a[6:0]});
  endtask

  // Drive one access, check hit, count stall cycles until release, then retire.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [9:0] a,
                        input logic exp_hit, input int exp_stall);
    int n;
    MemReadCpu = rd; MemWrite = wr; cpu_addr = a;
    #1;
    chk({tag, "_hit"}, {31'd0, hit}, {31'd0, exp_hit});
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk({tag, "_stall_cycles"}, n, exp_stall);
    tick();
    MemReadCpu = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    cpu_addr = 10'h0A4;
    tick(); tick();
    chk("rst_mem_rd",      {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_wr",      {31'd0, mem_wr}, 32'd0);
    chk("rst_cache_we",    {31'd0, cache_we}, 32'd0);
    chk("rst_cache_wsel",  {31'd0, cache_wsel}, 32'd0);
    chk("rst_mem_addr",    {22'd0, mem_addr}, 32'd0);
    chk("rst_cache_waddr", {25'd0, cache_waddr}, 32'd0);
    chk("rst_stall",       {31'd0, stall}, 32'd0);
    chk("rst_hit",         {31'd0, hit}, 32'd0);
    rst = 1'b0;
    tick();

    exp_refill(10'h0A4, 4);
    access("load_miss_0a4", 1'b1, 1'b0, 10'h0A4, 1'b0, 5);
    access("load_hit_0a4",  1'b1, 1'b0, 10'h0A4, 1'b1, 0);

    exp_store(10'h0A6, 1'b1);
    access("store_hit_0a6", 1'b0, 1'b1, 10'h0A6, 1'b1, 2);

    exp_store(10'h124, 1'b0);
    access("store_miss_124", 1'b0, 1'b1, 10'h124, 1'b0, 2);
    access("load_hit_after_store_miss", 1'b1, 1'b0, 10'h0A4, 1'b1, 0);

    wait_cfg = 2;
    exp_refill(10'h124, 4);
    access("load_miss_wait2", 1'b1, 1'b0, 10'h124, 1'b0, 13);
    access("load_hit_124", 1'b1, 1'b0, 10'h124, 1'b1, 0);
    wait_cfg = 0;
    tick();

    // reset while the third refill word is being returned
    exp_refill(10'h0C8, 3);
    MemReadCpu = 1'b1; cpu_addr = 10'h0C8;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; MemReadCpu = 1'b0;
    #1;
    chk("rst_mid_refill_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mid_refill_stall",  {31'd0, stall}, 32'd0);
    tick();
    exp_refill(10'h0A4, 4);
    access("load_miss_after_rst", 1'b1, 1'b0, 10'h0A4, 1'b0, 5);

    exp_store(10'h010, 1'b0);
    access("both_strobes", 1'b1, 1'b1, 10'h010, 1'b0, 2);
    tick(); tick();

    chk("mem_queue_drained", exp_mem.size(), 32'd0);
    chk("cw_queue_drained",  exp_cw.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
